// File: rtl/butterfly_pkg.sv
// rtl/butterfly_pkg.sv - shared constants and helpers for the butterfly serialisers
package butterfly_pkg;

  localparam logic MODE_SERIAL = 1'b0;
  localparam logic MODE_BYPASS = 1'b1;

  function automatic int num_beats(input int num_lane, input int out_lanes);
    return num_lane / out_lanes;
  endfunction

  // Only the low `width` bits of value are counted.
  function automatic int popcount(input logic [63:0] value, input int width);
    int n = 0;
    for (int i = 0; i < 64; i++) begin
      if (i < width && value[i]) n++;
    end
    return n;
  endfunction

endpackage

// File: rtl/butterfly_lane_group_sel.sv
// rtl/butterfly_lane_group_sel.sv - selects lane group grp of a word as one beat
module butterfly_lane_group_sel import butterfly_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANE   = 8,
  parameter int OUT_LANES  = 1,
  localparam int NUM_BEATS = num_beats(NUM_LANE, OUT_LANES),
  localparam int SEL_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1,
  localparam int BEAT_W    = OUT_LANES * DATA_WIDTH
) (
  input  logic [NUM_LANE*DATA_WIDTH-1:0] word,
  input  logic [SEL_W-1:0]               grp,
  output logic [BEAT_W-1:0]              beat
);

  always_comb begin
    beat = '0;
    for (int g = 0; g < NUM_BEATS; g++) begin
      if (grp == SEL_W'(g)) beat = word[g*BEAT_W +: BEAT_W];
    end
  end

endmodule

// File: rtl/butterfly_p2s_flex.sv
// rtl/butterfly_p2s_flex.sv - parallel-to-serial converter with bypass port and rotated emission
module butterfly_p2s_flex import butterfly_pkg::*; #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LANE   = 8,
  parameter int OUT_LANES  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_LANE*DATA_WIDTH-1:0] up_dat,
  input  logic                           up_vld,
  input  logic                           up_mode,
  output logic                           up_rdy,
  input  logic                           rot_en,
  input  logic                           cnt_clr,
  output logic [NUM_LANE*DATA_WIDTH-1:0] dn_parallel_dat,
  output logic                           dn_parallel_vld,
  input  logic                           dn_parallel_rdy,
  output logic [OUT_LANES*DATA_WIDTH-1:0] dn_serial_dat,
  output logic                           dn_serial_vld,
  input  logic                           dn_serial_rdy,
  output logic                           dn_serial_last,
  output logic                           busy
);

  localparam int NUM_BEATS = num_beats(NUM_LANE, OUT_LANES);
  localparam int SEL_W     = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;
  localparam int WORD_W    = NUM_LANE * DATA_WIDTH;
  localparam logic [SEL_W-1:0] LAST_BEAT = SEL_W'(NUM_BEATS - 1);

  typedef enum logic {IDLE, SER} state_t;

  state_t               state;
  logic [SEL_W-1:0]     beat;
  logic [SEL_W-1:0]     offset;
  logic [SEL_W-1:0]     next_offset;
  logic [SEL_W-1:0]     grp;
  logic [WORD_W-1:0]    word_q;
  logic [WORD_W-1:0]    par_dat;
  logic                 par_vld;
  logic [CNT_WIDTH-1:0] word_cnt;
  logic [CNT_WIDTH-1:0] cnt_eff;
  logic                 ser_vld;
  logic                 ser_xfer;
  logic                 last_xfer;
  logic                 rdy_ser;
  logic                 rdy_byp;
  logic                 ser_acc;
  logic                 byp_acc;

  assign ser_vld   = (state == SER);
  assign ser_xfer  = ser_vld & dn_serial_rdy;
  assign last_xfer = ser_xfer & (beat == LAST_BEAT);

  // A serial word may not overtake a pending bypass word, nor a bypass word an in-flight serial one.
  assign rdy_ser = (!ser_vld | last_xfer) & !par_vld;
  assign rdy_byp = !ser_vld & (!par_vld | dn_parallel_rdy);
  assign up_rdy  = rst_n & ((up_mode == MODE_BYPASS) ? rdy_byp : rdy_ser);
  assign ser_acc = up_vld & up_rdy & (up_mode == MODE_SERIAL);
  assign byp_acc = up_vld & up_rdy & (up_mode == MODE_BYPASS);

  assign cnt_eff     = cnt_clr ? '0 : word_cnt;
  // Truncation to SEL_W bits is the mod NUM_BEATS, since NUM_BEATS is a power of two.
  assign next_offset = (rot_en && NUM_BEATS > 1) ?
                       SEL_W'(popcount(64'(cnt_eff), CNT_WIDTH)) : '0;
  assign grp         = (NUM_BEATS > 1) ? beat + offset : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      beat     <= '0;
      offset   <= '0;
      word_q   <= '0;
      word_cnt <= '0;
      par_dat  <= '0;
      par_vld  <= 1'b0;
    end else begin
      if (ser_acc) begin
        state    <= SER;
        beat     <= '0;
        offset   <= next_offset;
        word_q   <= up_dat;
        word_cnt <= cnt_eff + CNT_WIDTH'(1);
      end else begin
        word_cnt <= cnt_eff;
        if (last_xfer) begin
          state <= IDLE;
          beat  <= '0;
        end else if (ser_xfer) begin
          beat <= beat + SEL_W'(1);
        end
      end
      if (byp_acc) begin
        par_dat <= up_dat;
        par_vld <= 1'b1;
      end else if (par_vld && dn_parallel_rdy) begin
        par_vld <= 1'b0;
      end
    end
  end

  butterfly_lane_group_sel #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_LANE   (NUM_LANE),
    .OUT_LANES  (OUT_LANES)
  ) u_sel (
    .word (word_q),
    .grp  (grp),
    .beat (dn_serial_dat)
  );

  assign dn_serial_vld   = ser_vld;
  assign dn_serial_last  = ser_vld & (beat == LAST_BEAT);
  assign dn_parallel_dat = par_dat;
  assign dn_parallel_vld = par_vld;
  assign busy            = ser_vld | par_vld;

endmodule

// File: tb/tb_butterfly_p2s_flex.sv
// tb/tb_butterfly_p2s_flex.sv - directed self-checking bench for butterfly_p2s_flex
module tb_butterfly_p2s_flex;

  localparam int DW = 16;
  localparam int NL = 8;
  localparam int WW = NL * DW;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [WW-1:0] up_dat;
  logic          up_vld, up_mode, up_rdy, rot_en, cnt_clr;
  logic [WW-1:0] p_dat;
  logic          p_vld, p_rdy;
  logic [DW-1:0] s_dat;
  logic          s_vld, s_rdy, s_last, busy;

  logic [WW-1:0] up_dat4, p_dat4;
  logic          up_vld4, up_rdy4, cnt_clr4, p_vld4, s_vld4, s_last4, busy4;
  logic          mode4 = 1'b0, rot4 = 1'b1, p_rdy4 = 1'b1, s_rdy4 = 1'b1;
  logic [4*DW-1:0] s_dat4;

  butterfly_p2s_flex #(.DATA_WIDTH(DW), .NUM_LANE(NL), .OUT_LANES(1), .CNT_WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .up_dat(up_dat), .up_vld(up_vld), .up_mode(up_mode),
    .up_rdy(up_rdy), .rot_en(rot_en), .cnt_clr(cnt_clr),
    .dn_parallel_dat(p_dat), .dn_parallel_vld(p_vld), .dn_parallel_rdy(p_rdy),
    .dn_serial_dat(s_dat), .dn_serial_vld(s_vld), .dn_serial_rdy(s_rdy),
    .dn_serial_last(s_last), .busy(busy)
  );

  butterfly_p2s_flex #(.DATA_WIDTH(DW), .NUM_LANE(NL), .OUT_LANES(4), .CNT_WIDTH(8)) dut4 (
    .clk(clk), .rst_n(rst_n), .up_dat(up_dat4), .up_vld(up_vld4), .up_mode(mode4),
    .up_rdy(up_rdy4), .rot_en(rot4), .cnt_clr(cnt_clr4),
    .dn_parallel_dat(p_dat4), .dn_parallel_vld(p_vld4), .dn_parallel_rdy(p_rdy4),
    .dn_serial_dat(s_dat4), .dn_serial_vld(s_vld4), .dn_serial_rdy(s_rdy4),
    .dn_serial_last(s_last4), .busy(busy4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Transfer log, stamped with the cycle number seen at the negedge.
  int            cyc = 0;
  logic [127:0]  s_dat_q[$];
  bit            s_last_q[$];
  int            s_cyc_q[$];
  int            sacc_q[$];
  int            bacc_q[$];
  logic [127:0]  p_dat_q[$];
  int            p_cyc_q[$];
  int            prise_q[$];
  bit            prev_stall = 1'b0;
  bit            prev_pvld = 1'b0;
  logic [DW-1:0] prev_dat = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (prev_stall) begin
        check("stall_hold_vld", s_vld, 1);
        check("stall_hold_dat", s_dat, prev_dat);
      end
      if (up_vld && up_rdy) begin
        if (up_mode) bacc_q.push_back(cyc);
        else sacc_q.push_back(cyc);
      end
      if (s_vld && s_rdy) begin
        s_dat_q.push_back(s_dat);
        s_last_q.push_back(s_last);
        s_cyc_q.push_back(cyc);
      end
      if (p_vld && !prev_pvld) prise_q.push_back(cyc);
      if (p_vld && p_rdy) begin
        p_dat_q.push_back(p_dat);
        p_cyc_q.push_back(cyc);
      end
    end
    prev_stall <= s_vld && !s_rdy;
    prev_dat   <= s_dat;
    prev_pvld  <= p_vld;
  end

  function automatic logic [WW-1:0] mk(input int base);
    logic [WW-1:0] r;
    for (int i = 0; i < NL; i++) r[i*DW +: DW] = DW'(base + i);
    return r;
  endfunction

  task automatic clear_mon();
    s_dat_q.delete(); s_last_q.delete(); s_cyc_q.delete();
    sacc_q.delete(); bacc_q.delete(); p_dat_q.delete(); p_cyc_q.delete(); prise_q.delete();
  endtask

  // Called at posedge+1; returns at posedge+1 right after the word is accepted.
  task automatic push(input logic [WW-1:0] d, input logic m, input logic clr);
    int n = 0;
    up_dat = d; up_mode = m; up_vld = 1'b1; cnt_clr = clr;
    @(negedge clk);
    while (!up_rdy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!up_rdy) check("push_timeout", 0, 1);
    @(posedge clk); #1;
    up_vld = 1'b0; cnt_clr = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_reached", busy, 0);
    @(posedge clk); #1;
  endtask

  task automatic chk_word(input string nm, input int idx, input int base, input int off);
    for (int b = 0; b < NL; b++) begin
      if (idx + b < s_dat_q.size()) begin
        check($sformatf("%s_dat_b%0d", nm, b), s_dat_q[idx+b], 128'(base + ((b + off) % NL)));
        check($sformatf("%s_last_b%0d", nm, b), s_last_q[idx+b], (b == NL - 1));
      end
    end
  endtask

  // dut4: one word, two 4-lane beats, no backpressure.
  task automatic run4(input string nm, input logic [WW-1:0] w, input logic clr, input int off);
    @(posedge clk); #1;
    up_dat4 = w; up_vld4 = 1'b1; cnt_clr4 = clr;
    @(negedge clk);
    check({nm, "_rdy"}, up_rdy4, 1);
    @(posedge clk); #1;
    up_vld4 = 1'b0; cnt_clr4 = 1'b0;
    for (int b = 0; b < 2; b++) begin
      @(negedge clk);
      check($sformatf("%s_vld_b%0d", nm, b), s_vld4, 1);
      check($sformatf("%s_dat_b%0d", nm, b), s_dat4, w[((b + off) % 2)*64 +: 64]);
      check($sformatf("%s_last_b%0d", nm, b), s_last4, (b == 1));
    end
  endtask

  int ta;
  int stall_at[2] = '{2, 5};
  int bp_cyc[8]   = '{1, 2, 6, 7, 8, 12, 13, 14};

  initial begin
    rst_n = 1'b0; up_vld = 1'b1; up_mode = 1'b0; up_dat = mk('h10);
    rot_en = 1'b0; cnt_clr = 1'b0; s_rdy = 1'b1; p_rdy = 1'b1;
    up_dat4 = mk('hA0); up_vld4 = 1'b1; cnt_clr4 = 1'b0;

    repeat (3) begin
      @(negedge clk);
      check("rst_up_rdy", up_rdy, 0);
      check("rst_s_vld", s_vld, 0);
      check("rst_s_last", s_last, 0);
      check("rst_s_dat", s_dat, 0);
      check("rst_p_vld", p_vld, 0);
      check("rst_p_dat", p_dat, 0);
      check("rst_busy", busy, 0);
      check("rst_up_rdy4", up_rdy4, 0);
    end
    @(posedge clk); #1;
    rst_n = 1'b1; up_vld = 1'b0; up_vld4 = 1'b0;
    @(negedge clk);
    check("post_rst_up_rdy", up_rdy, 1);
    @(posedge clk); #1;

    // Rotation straight out of reset: word_cnt 0..3 gives offsets 0,1,1,2.
    clear_mon();
    rot_en = 1'b1;
    push(mk('h30), 0, 0); push(mk('h40), 0, 0); push(mk('h50), 0, 0); push(mk('h60), 0, 0);
    wait_idle();
    check("rot_n_beats", s_dat_q.size(), 32);
    check("rot_n_acc", sacc_q.size(), 4);
    chk_word("rot_w0", 0, 'h30, 0);
    chk_word("rot_w1", 8, 'h40, 1);
    chk_word("rot_w2", 16, 'h50, 1);
    chk_word("rot_w3", 24, 'h60, 2);

    // Plain serial, back-to-back words.
    clear_mon();
    rot_en = 1'b0;
    push(mk('h10), 0, 0); push(mk('h20), 0, 0);
    wait_idle();
    check("ser_n_beats", s_dat_q.size(), 16);
    if (s_dat_q.size() == 16 && sacc_q.size() == 2) begin
      ta = sacc_q[0];
      check("ser_b0_cyc", s_cyc_q[0], ta + 1);
      check("ser_b7_cyc", s_cyc_q[7], ta + 8);
      check("ser_acc2_cyc", sacc_q[1], ta + 8);
      check("ser_w2b0_cyc", s_cyc_q[8], ta + 9);
    end
    chk_word("ser_w0", 0, 'h10, 0);
    chk_word("ser_w1", 8, 'h20, 0);

    // Standalone clear, then clear coincident with an accept (word_cnt was 2).
    rot_en = 1'b1; cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    clear_mon();
    push(mk('h50), 0, 0); push(mk('h60), 0, 0);
    wait_idle();
    push(mk('h70), 0, 1); push(mk('h80), 0, 0);
    wait_idle();
    check("clr_n_beats", s_dat_q.size(), 32);
    chk_word("clr_w0", 0, 'h50, 0);
    chk_word("clr_w1", 8, 'h60, 1);
    chk_word("clr_w2", 16, 'h70, 0);
    chk_word("clr_w3", 24, 'h80, 1);

    // Backpressure on beats 2 and 5, three cycles each.
    rot_en = 1'b0;
    clear_mon();
    fork
      begin
        push(mk('hA0), 0, 0);
        push(mk('hB0), 0, 0);
      end
      begin
        int n = 0;
        foreach (stall_at[k]) begin
          while (!(s_dat_q.size() == stall_at[k] && s_vld) && n < 100) begin
            @(posedge clk); #1;
            n++;
          end
          s_rdy = 1'b0;
          repeat (3) @(posedge clk);
          #1;
          s_rdy = 1'b1;
        end
      end
    join
    wait_idle();
    check("bp_n_beats", s_dat_q.size(), 16);
    if (s_dat_q.size() == 16 && sacc_q.size() == 2) begin
      ta = sacc_q[0];
      foreach (bp_cyc[b]) check($sformatf("bp_cyc_b%0d", b), s_cyc_q[b], ta + bp_cyc[b]);
      check("bp_acc2_cyc", sacc_q[1], ta + 14);
    end
    chk_word("bp_w0", 0, 'hA0, 0);
    chk_word("bp_w1", 8, 'hB0, 0);

    // Serial A, bypass B held off, serial C held off by pending B.
    clear_mon();
    p_rdy = 1'b0;
    push(mk('hC0), 0, 0);
    push(mk('hD0), 1, 0);
    fork
      push(mk('hE0), 0, 0);
      begin
        repeat (4) @(posedge clk);
        #1;
        p_rdy = 1'b1;
      end
    join
    wait_idle();
    check("mix_n_sacc", sacc_q.size(), 2);
    check("mix_n_bacc", bacc_q.size(), 1);
    check("mix_n_ptx", p_dat_q.size(), 1);
    if (sacc_q.size() == 2 && bacc_q.size() == 1 && p_dat_q.size() == 1 && prise_q.size() == 1) begin
      ta = sacc_q[0];
      check("mix_b_acc_cyc", bacc_q[0], ta + 9);
      check("mix_b_vld_cyc", prise_q[0], ta + 10);
      check("mix_b_tx_cyc", p_cyc_q[0], ta + 14);
      check("mix_b_dat", p_dat_q[0], mk('hD0));
      check("mix_c_acc_cyc", sacc_q[1], ta + 15);
    end
    chk_word("mix_a", 0, 'hC0, 0);
    chk_word("mix_c", 8, 'hE0, 0);

    // Back-to-back bypass words with the parallel port always ready.
    clear_mon();
    push(mk('h11), 1, 0); push(mk('h21), 1, 0);
    wait_idle();
    check("byp_n_tx", p_dat_q.size(), 2);
    if (p_dat_q.size() == 2 && bacc_q.size() == 2) begin
      check("byp_acc2_cyc", bacc_q[1], bacc_q[0] + 1);
      check("byp_tx0_cyc", p_cyc_q[0], bacc_q[0] + 1);
      check("byp_tx1_cyc", p_cyc_q[1], bacc_q[0] + 2);
      check("byp_tx0_dat", p_dat_q[0], mk('h11));
      check("byp_tx1_dat", p_dat_q[1], mk('h21));
    end

    // OUT_LANES = 4: word_cnt 0, 1, then clear-with-accept, then 1 again.
    run4("g4_w0", mk('hA0), 0, 0);
    run4("g4_w1", mk('hB0), 0, 1);
    run4("g4_w2", mk('hC0), 1, 0);
    run4("g4_w3", mk('hD0), 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/butterfly_p2s_flex.md
# butterfly_p2s_flex

Parametrised parallel-to-serial converter for the butterfly datapath. It accepts one NUM_LANE-wide word per handshake. Per word, it either forwards the word on the parallel bypass port, or serialises it into lane groups of OUT_LANES lanes on the serial port, with optional per-word rotation of the emission order. Both downstream ports have full valid/ready backpressure. It sits between the butterfly compute array and the narrow write-back/stream path.

## Interface
- DATA_WIDTH, 16, bits per lane
- NUM_LANE, 8, lanes per input word; power of two, ≥2
- OUT_LANES, 1, lanes per serial beat; power of two, divides NUM_LANE; NUM_BEATS = NUM_LANE/OUT_LANES
- CNT_WIDTH, 8, width of serial word counter used for rotation
- clk  in  1  single clock, all logic rising-edge
- rst_n  in  1  reset, synchronous, active-low
- up_dat  in  NUM_LANE*DATA_WIDTH  input word; lane i = bits [DATA_WIDTH*i +: DATA_WIDTH]
- up_vld  in  1  input valid
- up_mode  in  1  per-word mode, qualified by up_vld: 1 = bypass, 0 = serial
- up_rdy  out  1  input ready
- rot_en  in  1  quasi-static; 1 = rotate serial emission order
- cnt_clr  in  1  synchronous clear of serial word counter
- dn_parallel_dat  out  NUM_LANE*DATA_WIDTH  bypass data
- dn_parallel_vld  out  1  bypass valid
- dn_parallel_rdy  in  1  bypass ready
- dn_serial_dat  out  OUT_LANES*DATA_WIDTH  serial beat
- dn_serial_vld  out  1  serial valid
- dn_serial_rdy  in  1  serial ready
- dn_serial_last  out  1  marks final beat of a word
- busy  out  1  serial word in flight or parallel output valid

## Operation
- Handshake: a transfer occurs when vld & rdy are both high on a port. Once vld is raised, it and its data hold stable until the transfer.
- States: IDLE and SER.
  - Serial accept: IDLE → SER. Latch the word, set beat = 0, latch offset.
  - Last-beat transfer: SER → IDLE, unless a new serial word is accepted in the same cycle, which keeps SER with beat = 0.
- Serial beat b emits lane group g = (b + offset) mod NUM_BEATS, i.e. lanes [g*OUT_LANES, g*OUT_LANES+OUT_LANES-1]; the lowest lane occupies the LSBs.
- Offset:
  - rot_en = 0: offset = 0.
  - rot_en = 1: offset = popcount(word_cnt) mod NUM_BEATS, where word_cnt is sampled in the accept cycle.
- word_cnt (CNT_WIDTH bits):
  - Increments on each serial-word accept and wraps mod 2^CNT_WIDTH.
  - cnt_clr forces word_cnt to 0 before use. A word accepted in the same cycle uses 0, and word_cnt becomes 1.
- dn_serial_last = dn_serial_vld & (beat == NUM_BEATS-1).
- Bypass words go into a one-entry parallel output register.
- Ordering: words leave in acceptance order across both ports.
- up_rdy:
  - Serial word: (state == IDLE or last-beat transfer this cycle) and no parallel word pending.
  - Bypass word: state == IDLE (no serial word in flight) and (!dn_parallel_vld or dn_parallel_rdy).
  - up_rdy depends on up_mode; combinational from up_mode is allowed.
- Reset values: all outputs 0, state IDLE, word_cnt 0, beat 0, data registers 0.
- Reset mid-word drops the in-flight word and any pending bypass word.

## Timing
- Serial accept at cycle T → beat 0 valid at T+1. Beat k is valid at T+1+k with no stalls; each stall cycle adds one.
- Back-to-back serial words achieve 100% throughput: the next word is accepted in the cycle of the last-beat transfer.
- Bypass accept at T → dn_parallel_vld at T+1; cleared after transfer unless a new bypass word is accepted in the same cycle.
- No combinational path from dn_*_rdy to dn_*_dat. A combinational path from dn_*_rdy to up_rdy is permitted.
- rot_en changes take effect only for words accepted afterwards.

## Structure
- Shared package butterfly_pkg:
  - function num_beats(NUM_LANE, OUT_LANES)
  - function popcount(CNT_WIDTH)
  - mode constants MODE_SERIAL = 1'b0, MODE_BYPASS = 1'b1
- One sub-module butterfly_lane_group_sel: combinational group-select mux from latched word and g to a beat. It is parameterised identically and reusable by the s2p counterpart.
- The top level holds the FSM, counters, word register and parallel register.

## Test plan
- Reset: hold rst_n low for 3 cycles with up_vld = 1 → all outputs 0, up_rdy = 0 during reset; word_cnt = 0 after release.
- Serial, NUM_LANE = 8, OUT_LANES = 1, rot_en = 0, lanes 0x10..0x17, dn_serial_rdy = 1 → beats 0x10..0x17 at T+1..T+8, last only on 0x17. A second word accepted at T+8 gives its beat 0 at T+9.
- Rotation, rot_en = 1, after cnt_clr send 4 words (word_cnt 0..3) → offsets 0,1,1,2; word 3 emits lanes 2,3,4,5,6,7,0,1.
- Backpressure: drop dn_serial_rdy on beats 2 and 5 for 3 cycles each → data and vld hold stable, no beat lost or duplicated, up_rdy low until the last-beat transfer.
- Mode interleave: serial word A, then bypass word B presented immediately → B held off (up_rdy = 0) until A's last beat. B appears on dn_parallel at the cycle after acceptance. With dn_parallel_rdy = 0, a following serial word C is stalled until B transfers.
- OUT_LANES = 4, NUM_LANE = 8, rot_en = 1, word_cnt = 1 → 2 beats: lanes {4..7} then {0..3}, last on beat 2; cnt_clr coincident with accept → offset 0 and word_cnt = 1.
